// File: rtl/coeff_load_sequencer.sv
// Walks NUM_COEFF coefficient indices (ascending or descending), one load strobe per index,
// gated by modwait, with an optional fixed settle gap; a new request restarts the set.
module coeff_load_sequencer #(
    parameter int  NUM_COEFF     = 4,
    parameter int  SETTLE_CYCLES = 0,
    localparam int IDX_W         = $clog2(NUM_COEFF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_coefficient_set,
    input  logic             modwait,
    input  logic             reverse_order,
    output logic             load_coeff,
    output logic [IDX_W-1:0] coefficient_num,
    output logic             busy,
    output logic             load_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_COEFF - 1);
    localparam bit               HAS_SETTLE  = (SETTLE_CYCLES > 0);
    localparam logic [7:0]       SETTLE_INIT = HAS_SETTLE ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dir_q, dir_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             is_last;
    logic             load_c;

    assign is_last = dir_q ? (idx_q == '0) : (idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        // A request in any state (re)starts the set and overrides everything else.
        if (new_coefficient_set) begin
            dir_d   = reverse_order;
            idx_d   = reverse_order ? LAST_IDX : '0;
            cnt_d   = 8'd0;
            state_d = ISSUE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    idx_d = '0;
                end
                ISSUE: begin
                    if (!modwait) begin
                        load_c = 1'b1;
                        if (is_last) begin
                            state_d = DONE;
                        end else begin
                            idx_d = dir_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
                            if (HAS_SETTLE) begin
                                state_d = SETTLE;
                                cnt_d   = SETTLE_INIT;
                            end
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ISSUE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                DONE: begin
                    idx_d   = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign load_coeff      = load_c;
    assign coefficient_num = (state_q == IDLE) ? '0 : idx_q;
    assign busy            = (state_q != IDLE);
    assign load_done       = (state_q == DONE) && !new_coefficient_set;

endmodule

// File: tb/tb_coeff_load_sequencer.sv
// Directed bench: three sequencer configurations, per-cycle output checks against hand-derived timelines.
module tb_coeff_load_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       modwait;
    logic       reverse_order;
    logic       req_a, req_b, req_c;
    logic       lc_a, lc_b, lc_c;
    logic [1:0] num_a, num_c;
    logic [2:0] num_b;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: 4 coefficients, no settle gap
    coeff_load_sequencer #(.NUM_COEFF(4), .SETTLE_CYCLES(0)) u_dut_a (
        .clk(clk), .rst(rst), .new_coefficient_set(req_a), .modwait(modwait),
        .reverse_order(reverse_order), .load_coeff(lc_a), .coefficient_num(num_a),
        .busy(busy_a), .load_done(done_a));

    // B: 5 coefficients, 2-cycle settle gap
    coeff_load_sequencer #(.NUM_COEFF(5), .SETTLE_CYCLES(2)) u_dut_b (
        .clk(clk), .rst(rst), .new_coefficient_set(req_b), .modwait(modwait),
        .reverse_order(reverse_order), .load_coeff(lc_b), .coefficient_num(num_b),
        .busy(busy_b), .load_done(done_b));

    // C: 4 coefficients, 2-cycle settle gap
    coeff_load_sequencer #(.NUM_COEFF(4), .SETTLE_CYCLES(2)) u_dut_c (
        .clk(clk), .rst(rst), .new_coefficient_set(req_c), .modwait(modwait),
        .reverse_order(reverse_order), .load_coeff(lc_c), .coefficient_num(num_c),
        .busy(busy_c), .load_done(done_c));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Check one cycle's outputs at the falling edge, then advance to just after the next rising edge.
    // e_num < 0 means coefficient_num is don't-care this cycle.
    task automatic cyc(input int sel, input string tag, input int e_load, input int e_num,
                       input int e_busy, input int e_done);
        logic        l, b, d;
        logic [31:0] n;
        @(negedge clk);
        case (sel)
            0:       begin l = lc_a; n = 32'(num_a); b = busy_a; d = done_a; end
            1:       begin l = lc_b; n = 32'(num_b); b = busy_b; d = done_b; end
            default: begin l = lc_c; n = 32'(num_c); b = busy_c; d = done_c; end
        endcase
        check_eq({tag, "/load"}, 32'(l), 32'(e_load));
        if (e_num >= 0) check_eq({tag, "/num"}, n, 32'(e_num));
        check_eq({tag, "/busy"}, 32'(b), 32'(e_busy));
        check_eq({tag, "/done"}, 32'(d), 32'(e_done));
        if (sel == 1) check_eq({tag, "/range"}, 32'(n <= 32'd4), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Request on A followed by the plain 0..3 back-to-back sequence.
    task automatic run_a_plain(input string tag);
        req_a = 1'b1;
        cyc(0, {tag, "_req"}, 0, 0, 0, 0);
        req_a = 1'b0;
        for (int k = 0; k < 4; k++) cyc(0, {tag, "_strobe"}, 1, k, 1, 0);
        cyc(0, {tag, "_done"}, 0, -1, 1, 1);
        cyc(0, {tag, "_idle"}, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; modwait = 1'b0; reverse_order = 1'b0;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        #1;
        cyc(0, "rst_a", 0, 0, 0, 0);
        cyc(1, "rst_b", 0, 0, 0, 0);
        cyc(2, "rst_c", 0, 0, 0, 0);
        rst = 1'b0;
        cyc(0, "idle_a", 0, 0, 0, 0);

        // Back-to-back forward load
        run_a_plain("fwd");

        // modwait stalls strobes without losing the index
        req_a = 1'b1;
        cyc(0, "mw_req", 0, 0, 0, 0);
        req_a = 1'b0;
        cyc(0, "mw_s0", 1, 0, 1, 0);
        modwait = 1'b1;
        for (int k = 0; k < 3; k++) cyc(0, "mw_hold", 0, -1, 1, 0);
        modwait = 1'b0;
        for (int k = 1; k < 4; k++) cyc(0, "mw_s", 1, k, 1, 0);
        cyc(0, "mw_done", 0, -1, 1, 1);
        cyc(0, "mw_idle", 0, 0, 0, 0);

        // Reverse order, non-power-of-two count, settle gaps; direction latched at start only
        reverse_order = 1'b1;
        req_b = 1'b1;
        cyc(1, "rev_req", 0, 0, 0, 0);
        req_b = 1'b0;
        reverse_order = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            cyc(1, "rev_s", 1, k, 1, 0);
            if (k > 0) begin
                cyc(1, "rev_gap", 0, -1, 1, 0);
                cyc(1, "rev_gap", 0, -1, 1, 0);
            end
        end
        cyc(1, "rev_done", 0, -1, 1, 1);
        cyc(1, "rev_idle", 0, 0, 0, 0);

        // Restart during the settle gap after idx1
        req_c = 1'b1;
        cyc(2, "rs_req", 0, 0, 0, 0);
        req_c = 1'b0;
        cyc(2, "rs_s0", 1, 0, 1, 0);
        cyc(2, "rs_gap", 0, -1, 1, 0);
        cyc(2, "rs_gap", 0, -1, 1, 0);
        cyc(2, "rs_s1", 1, 1, 1, 0);
        req_c = 1'b1;
        cyc(2, "rs_restart", 0, -1, 1, 0);
        req_c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(2, "rs_s", 1, k, 1, 0);
            if (k < 3) begin
                cyc(2, "rs_gap2", 0, -1, 1, 0);
                cyc(2, "rs_gap2", 0, -1, 1, 0);
            end
        end
        cyc(2, "rs_done", 0, -1, 1, 1);
        cyc(2, "rs_idle", 0, 0, 0, 0);

        // Asynchronous reset mid-sequence, in ISSUE after the idx2 strobe
        req_a = 1'b1;
        cyc(0, "ar_req", 0, 0, 0, 0);
        req_a = 1'b0;
        for (int k = 0; k < 3; k++) cyc(0, "ar_s", 1, k, 1, 0);
        rst = 1'b1;
        cyc(0, "ar_inrst", 0, 0, 0, 0);
        rst = 1'b0;
        cyc(0, "ar_after", 0, 0, 0, 0);
        cyc(0, "ar_after2", 0, 0, 0, 0);
        run_a_plain("ar_again");

        // Request coincident with DONE suppresses load_done and restarts
        req_a = 1'b1;
        cyc(0, "dn_req", 0, 0, 0, 0);
        req_a = 1'b0;
        for (int k = 0; k < 4; k++) cyc(0, "dn_s", 1, k, 1, 0);
        req_a = 1'b1;
        cyc(0, "dn_restart", 0, -1, 1, 0);
        req_a = 1'b0;
        for (int k = 0; k < 4; k++) cyc(0, "dn_s2", 1, k, 1, 0);
        cyc(0, "dn_done", 0, -1, 1, 1);
        cyc(0, "dn_idle", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coeff_load_sequencer.md
Name: coeff_load_sequencer

Overview:
- Parametrised coefficient-load sequencer for the FIR datapath.
- On a new-coefficient-set request, it walks a configurable number of coefficient indices and issues one load strobe per index to the coefficient register file.
- Each strobe is gated by the downstream modwait busy flag. An optional settle gap follows every strobe.
- Adds reverse-order loading, restart-on-new-request, and busy/done status.

Parameters:
- NUM_COEFF, default 4: number of coefficients per set. Must be >= 2.
- SETTLE_CYCLES, default 0: idle cycles inserted after each load strobe before the next one. Range 0..255.
- IDX_W, default $clog2(NUM_COEFF): index width. This is a localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- new_coefficient_set  in  1  request to load a full set. Level sampled each cycle; a one-cycle pulse is sufficient.
- modwait  in  1  downstream busy flag. While high, no load strobe is issued.
- reverse_order  in  1  selects the load order. 0 = index 0 up to NUM_COEFF-1; 1 = NUM_COEFF-1 down to 0. Sampled only when a load starts or restarts.
- load_coeff  out  1  load strobe. Asserted for exactly one cycle per coefficient.
- coefficient_num  out  IDX_W  index of the coefficient being loaded. Valid whenever load_coeff=1.
- busy  out  1  high whenever state != IDLE.
- load_done  out  1  one-cycle pulse after the final coefficient strobe.

Behaviour:
- Reset (rst=1, asynchronous):
  - State = IDLE, all outputs 0.
  - Settle counter and latched direction cleared.
  - Reset mid-sequence abandons the set immediately; no strobe or done pulse follows.
- Registers: state, idx (drives coefficient_num), dir, settle counter (8 bits).
- load_coeff is combinational from state and modwait. load_done and busy decode from state.
- States: IDLE, ISSUE, SETTLE, DONE.
- IDLE:
  - coefficient_num = 0.
  - If new_coefficient_set=1: dir <= reverse_order; idx <= (reverse_order ? NUM_COEFF-1 : 0); next state ISSUE.
  - busy rises on the cycle after the request.
- ISSUE:
  - If modwait=1: hold; load_coeff=0.
  - If modwait=0: load_coeff=1 this cycle, with coefficient_num = idx.
  - If idx is the last index (NUM_COEFF-1 when dir=0, 0 when dir=1): next state DONE.
  - Otherwise idx steps +1 (dir=0) or -1 (dir=1), with no wrap. Next state is SETTLE (counter <= SETTLE_CYCLES-1) if SETTLE_CYCLES>0, else ISSUE.
  - With SETTLE_CYCLES=0 and modwait held low, strobes are back-to-back: NUM_COEFF consecutive cycles.
- SETTLE:
  - load_coeff=0; counter decrements each cycle.
  - At counter==0, next state ISSUE.
  - Gives exactly SETTLE_CYCLES strobe-free cycles between strobes, independent of modwait.
- DONE:
  - load_done=1 for one cycle; busy still 1.
  - idx <= 0; next state IDLE.
- Latency: request at cycle T gives the first strobe at T+1 at the earliest (modwait=0). load_done follows the final strobe by 1 cycle.
- Restart: new_coefficient_set=1 in ISSUE, SETTLE or DONE has priority over all other actions.
  - load_coeff is forced to 0 that cycle and load_done is suppressed.
  - dir is re-sampled, idx reloads to the start index, settle counter clears, next state ISSUE.
  - The set reloads from the start; no partial-set completion is signalled.
- modwait has no effect in IDLE, SETTLE or DONE.
- coefficient_num never exceeds NUM_COEFF-1 and never wraps. Non-power-of-two NUM_COEFF (e.g. 3, 5) is supported.

Test Plan:
- NUM_COEFF=4, SETTLE=0, modwait=0, reverse=0, 1-cycle request at T -> load_coeff high T+1..T+4 with coefficient_num 0,1,2,3; load_done at T+5; busy T+1..T+5; IDLE at T+6.
- Same configuration with modwait=1 during T+2..T+4 -> strobe idx0 at T+1, idx1 at T+5, idx2 at T+6, idx3 at T+7; load_done at T+8; no strobe while modwait=1.
- NUM_COEFF=5, SETTLE=2, reverse=1 -> strobes with idx 4,3,2,1,0, each separated by exactly 2 dead cycles; load_done 1 cycle after idx0; coefficient_num never 5..7.
- NUM_COEFF=4, second request during the SETTLE after the idx1 strobe -> no strobe that cycle; sequence restarts at idx0 and completes 0..3 with a single load_done.
- rst pulsed while in ISSUE after idx2 -> all outputs 0 immediately; no load_done; a subsequent request starts cleanly from idx0.
- Request coincident with the DONE cycle -> load_done suppressed; full new sequence issued; exactly one load_done at its end.
